dmem_arbiter: RTL

//  Shares the single-port data memory between the core load/store path (port C) and a
//  DMA/debug loader (port D). Each port uses a valid/ready request channel and gets a
//  one-cycle response pulse. The arbiter registers the granted request onto the memory

---
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core load/store
// path (port C) and the DMA/debug loader (port D). C has fixed priority; D is
// forced ahead after MAX_WAIT consecutive C grants while D was waiting.
// One registered memory op per two cycles, one-cycle response pulse per op.
//
// state  | meaning
// IDLE   | nothing in flight; grant evaluated, a request may be accepted
// ACCESS | granted op on the memory bus; write commits / read captured at end
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        c_req_valid,
    output logic        c_req_ready,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [2:0]  c_type,
    input  logic [31:0] c_wdata,
    output logic        c_rsp_valid,
    output logic [31:0] c_rdata,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_type,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rdata,
    output logic        m_memwrite,
    output logic [31:0] m_addr,
    output logic [2:0]  m_load_type,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        owner_is_d_q, owner_is_d_d;
    logic        load_ok_q, load_ok_d;
    logic        m_memwrite_q, m_memwrite_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [2:0]  m_load_type_q, m_load_type_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        c_rsp_valid_q, c_rsp_valid_d;
    logic        d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        grant_c, grant_d;
    logic        sel_we, sel_legal;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_type;

    // Byte always legal, half needs even address, word needs 4-byte alignment.
    function automatic logic is_legal(input logic [2:0] t, input logic [1:0] a);
        case (t)
            3'b000:  is_legal = 1'b1;
            3'b001:  is_legal = ~a[0];
            3'b010:  is_legal = (a == 2'b00);
            default: is_legal = 1'b0;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: any valid request starts an access; an access lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (c_req_valid || d_req_valid) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant: C by default, D when C is idle or D has waited MAX_WAIT C grants.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (d_req_valid && (!c_req_valid || wait_cnt_q == MAX_WAIT_C)) grant_d = 1'b1;
            else if (c_req_valid)                                         grant_c = 1'b1;
        end
    end

    assign c_req_ready = grant_c & resetn;
    assign d_req_ready = grant_d & resetn;

    // Payload of the winning port.
    always_comb begin
        sel_we    = grant_d ? d_we    : c_we;
        sel_addr  = grant_d ? d_addr  : c_addr;
        sel_type  = grant_d ? d_type  : c_type;
        sel_wdata = grant_d ? d_wdata : c_wdata;
        sel_legal = is_legal(sel_type, sel_addr[1:0]);
    end

    // Starvation counter: counts C grants taken while D waits, cleared when D wins.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant_d)
            wait_cnt_d = 4'd0;
        else if (grant_c && d_req_valid && wait_cnt_q < MAX_WAIT_C)
            wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Memory bus launch on accept, read capture and response at the end of ACCESS.
    always_comb begin
        m_memwrite_d  = 1'b0;
        m_addr_d      = m_addr_q;
        m_load_type_d = m_load_type_q;
        m_wdata_d     = m_wdata_q;
        owner_is_d_d  = owner_is_d_q;
        load_ok_d     = load_ok_q;
        c_rsp_valid_d = 1'b0;
        d_rsp_valid_d = 1'b0;
        c_rdata_d     = c_rdata_q;
        d_rdata_d     = d_rdata_q;
        if (grant_c || grant_d) begin
            m_memwrite_d  = sel_we & sel_legal;
            m_addr_d      = sel_addr;
            m_load_type_d = sel_type;
            m_wdata_d     = sel_wdata;
            owner_is_d_d  = grant_d;
            load_ok_d     = ~sel_we & sel_legal;
        end
        if (state_q == ACCESS) begin
            if (owner_is_d_q) begin
                d_rsp_valid_d = 1'b1;
                d_rdata_d     = load_ok_q ? m_rdata : 32'h0;
            end else begin
                c_rsp_valid_d = 1'b1;
                c_rdata_d     = load_ok_q ? m_rdata : 32'h0;
            end
        end
    end

    // Datapath registers; reset aborts any in-flight op without a response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q    <= 4'd0;
            owner_is_d_q  <= 1'b0;
            load_ok_q     <= 1'b0;
            m_memwrite_q  <= 1'b0;
            m_addr_q      <= 32'h0;
            m_load_type_q <= 3'b000;
            m_wdata_q     <= 32'h0;
            c_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            c_rdata_q     <= 32'h0;
            d_rdata_q     <= 32'h0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            owner_is_d_q  <= owner_is_d_d;
            load_ok_q     <= load_ok_d;
            m_memwrite_q  <= m_memwrite_d;
            m_addr_q      <= m_addr_d;
            m_load_type_q <= m_load_type_d;
            m_wdata_q     <= m_wdata_d;
            c_rsp_valid_q <= c_rsp_valid_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            c_rdata_q     <= c_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign m_memwrite  = m_memwrite_q;
    assign m_addr      = m_addr_q;
    assign m_load_type = m_load_type_q;
    assign m_wdata     = m_wdata_q;
    assign c_rsp_valid = c_rsp_valid_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign c_rdata     = c_rdata_q;
    assign d_rdata     = d_rdata_q;

endmodule
